ut_datapath_gen: RTL
====================

Name: ut_datapath_gen

Overview:
Parametrised successor to the fixed 8-bit processing unit (UT) datapath.
- Datapath: accumulator, register bank of NREG registers, carry and zero flags, 4-bit ALU opcode.
- Adds one multi-cycle unsigned multiply with a busy/done handshake.
- Sits under the chip top; all control comes from pins or an external sequencer.

Parameters:
- WIDTH, 8: datapath width in bits (>=4).
- NREG, 4: number of bank registers (power of two, >=2); RAW = $clog2(NREG).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ce  in  1  clock enable; low freezes all state, including the multiply counter.
- sel_ual  in  4  ALU opcode.
- src_sel  in  RAW  bank register used as ALU operand R.
- dst_sel  in  RAW  bank register written by load_reg and by MUL.
- load_reg  in  1  R[dst_sel] <= data_in.
- load_accu  in  1  accu <= ALU result; starts MUL when sel_ual=MUL.
- load_carry  in  1  carry <= ALU carry-out.
- init_carry  in  1  carry <= 0.
- data_in  in  WIDTH  external operand.
- data_out  out  WIDTH  accumulator value.
- rd_data  out  WIDTH  R[src_sel], combinational read.
- carry  out  1  carry flag.
- zero  out  1  high when accu==0.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when the multiply completes.

Behaviour:
Reset:
- accu, all R, carry = 0; zero = 1; busy = 0; done = 0; FSM = IDLE.

Opcodes (A = accu, R = R[src_sel], C = carry):
- 0 PASS_R: R.
- 1 AND, 2 OR, 3 XOR: A op R.
- 4 ADD: A+R+C; cout = bit WIDTH of the sum.
- 5 SUB: A-R-C; cout = borrow.
- 6 SHL: {cout,res} = {A,C}.
- 7 SHR: {res,cout} = {C,A}.
- 8 NOT: ~A.
- 9 PASS_IN: data_in.
- 10 MUL: multi-cycle, see below.
- 11-15 reserved: result = A, cout = C.
- For all non-arithmetic ops, cout = C.

Single-cycle ops (ce=1, FSM IDLE):
- load_accu: accu <= res.
- load_reg: R[dst_sel] <= data_in.
- init_carry has priority over load_carry.
- All three writes may occur in the same cycle.
- zero is registered: it reflects accu after each accu write.

MUL:
- States IDLE, MUL, DONE.
- Trigger: IDLE with ce & load_accu & sel_ual=10 latches A and R.
- Then busy = 1 for exactly WIDTH enabled cycles of shift-add.
- Then DONE for one cycle: done = 1, busy = 0; accu <= product[WIDTH-1:0]; R[dst_sel captured at start] <= product[2W-1:W]; carry <= 0; zero updated.
- Then back to IDLE.
- While busy, all load_*/init_carry inputs are ignored; rd_data stays live.
- A new MUL may be triggered in the cycle after DONE.
- rst mid-operation aborts immediately: everything returns to reset values and no done pulse is produced.
- ce=0 stalls the FSM and counter; done stays high until the next enabled cycle.

Optional Feature:
Macro UT_SAT_EN.
- Defined: ADD clamps to all-ones on carry-out; SUB clamps to 0 on borrow. cout is still reported unchanged.
- Undefined: ADD/SUB results wrap modulo 2^WIDTH.

Decomposition:
- Package ut_pkg: opcode enum (OP_PASS_R .. OP_MUL), FSM state enum, OPW=4.
- One sub-module ut_alu: combinational, parametrised by WIDTH, covering opcodes 0-9 and 11-15, outputs res and cout. The sequential multiplier lives in ut_datapath_gen.

Test Plan (WIDTH=8, NREG=4):
- Reset: rst pulse -> data_out=0x00, carry=0, zero=1, busy=0, done=0; rst asserted asynchronously mid-cycle clears immediately.
- ADD with carry: load_reg dst=0 data_in=0x0F; PASS_IN 0xF3 + load_accu; ADD src=0 + load_accu + load_carry -> data_out=0x02, carry=1, zero=0.
- SUB borrow and flag priority: accu=0x05, R1=0x07, init_carry then SUB src=1 + load_carry -> data_out=0xFE, carry=1. Same cycle with init_carry and load_carry both high -> carry=0.
- MUL: accu=0xFF, R2=0xFF, MUL src=2 dst=3 -> busy high 8 cycles, done pulse on the 9th, data_out=0x01, R3=0xFE, carry=0. Loads issued while busy have no effect.
- Stall and abort: ce low for 3 cycles during MUL -> done is delayed by 3 cycles, same result. rst at busy cycle 4 -> busy=0, no done pulse, accu=0.
- UT_SAT_EN: accu=0xF0, R0=0x20, ADD -> data_out=0xFF, carry=1 (macro defined) vs 0x10, carry=1 (macro undefined).

Source files
------------

// File: rtl/ut_pkg.sv
// Shared definitions for the parametrised UT datapath: ALU opcodes and multiply FSM states.
package ut_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_PASS_R  = 4'd0,
    OP_AND     = 4'd1,
    OP_OR      = 4'd2,
    OP_XOR     = 4'd3,
    OP_ADD     = 4'd4,
    OP_SUB     = 4'd5,
    OP_SHL     = 4'd6,
    OP_SHR     = 4'd7,
    OP_NOT     = 4'd8,
    OP_PASS_IN = 4'd9,
    OP_MUL     = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ut_alu.sv
// Combinational single-cycle ALU of the UT datapath (everything except MUL).
// Define UT_SAT_EN to make ADD/SUB saturate instead of wrapping.
module ut_alu
  import ut_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] d,
  input  logic             c,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, r} + {{WIDTH{1'b0}}, c};
    diff = {1'b0, a} - {1'b0, r} - {{WIDTH{1'b0}}, c};
    res  = a;
    cout = c;
    case (op)
      OP_PASS_R:  res = r;
      OP_AND:     res = a & r;
      OP_OR:      res = a | r;
      OP_XOR:     res = a ^ r;
      OP_ADD: begin
        cout = sum[WIDTH];
`ifdef UT_SAT_EN
        res  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        res  = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        // bit WIDTH of the extended difference is the borrow
        cout = diff[WIDTH];
`ifdef UT_SAT_EN
        res  = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
        res  = diff[WIDTH-1:0];
`endif
      end
      OP_SHL: begin
        res  = {a[WIDTH-2:0], c};
        cout = a[WIDTH-1];
      end
      OP_SHR: begin
        res  = {c, a[WIDTH-1:1]};
        cout = a[0];
      end
      OP_NOT:     res = ~a;
      OP_PASS_IN: res = d;
      default: begin
        res  = a;
        cout = c;
      end
    endcase
  end

endmodule

// File: rtl/ut_datapath_gen.sv
// UT datapath top: accumulator, register bank, flags and a WIDTH-cycle shift-add multiplier.
// Optional saturating ADD/SUB via macro UT_SAT_EN (handled inside ut_alu).
module ut_datapath_gen
  import ut_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int RAW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [OPW-1:0]   sel_ual,
  input  logic [RAW-1:0]   src_sel,
  input  logic [RAW-1:0]   dst_sel,
  input  logic             load_reg,
  input  logic             load_accu,
  input  logic             load_carry,
  input  logic             init_carry,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_e                        state_reg;
  logic [WIDTH-1:0]              accu_reg;
  logic                          carry_reg;
  logic                          zero_reg;
  logic [WIDTH-1:0]              mul_a_reg;
  logic [2*WIDTH-1:0]            prod_reg;
  logic [CW-1:0]                 cnt_reg;
  logic [RAW-1:0]                mul_dst_reg;
  logic [NREG-1:0][WIDTH-1:0]    bank;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout;
  logic               idle;
  logic               is_mul_op;
  logic               mul_trig;
  logic               mul_last;
  logic [WIDTH:0]     upper_next;
  logic [2*WIDTH-1:0] prod_next;
  logic               accu_we;
  logic [WIDTH-1:0]   accu_next;
  logic               reg_we;
  logic [RAW-1:0]     reg_idx;
  logic [WIDTH-1:0]   reg_next;

  ut_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (sel_ual),
    .a    (accu_reg),
    .r    (bank[src_sel]),
    .d    (data_in),
    .c    (carry_reg),
    .res  (alu_res),
    .cout (alu_cout)
  );

  always_comb begin
    idle      = (state_reg == ST_IDLE);
    is_mul_op = (sel_ual == OP_MUL);
    mul_trig  = ce && idle && load_accu && is_mul_op;
    mul_last  = ce && (state_reg == ST_MUL) && (cnt_reg == CW'(WIDTH - 1));
    // One shift-add step: conditionally add the multiplicand to the upper half, then shift right.
    upper_next = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mul_a_reg} : '0);
    prod_next  = {upper_next, prod_reg[WIDTH-1:1]};
    accu_we    = (ce && idle && load_accu && !is_mul_op) || mul_last;
    accu_next  = mul_last ? prod_next[WIDTH-1:0] : alu_res;
    reg_we     = (ce && idle && load_reg) || mul_last;
    reg_idx    = mul_last ? mul_dst_reg : dst_sel;
    reg_next   = mul_last ? prod_next[2*WIDTH-1:WIDTH] : data_in;
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_bank
    logic [WIDTH-1:0] r_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_reg <= '0;
      end else if (reg_we && (reg_idx == RAW'(gi))) begin
        r_reg <= reg_next;
      end
    end
    assign bank[gi] = r_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accu_reg  <= '0;
      zero_reg  <= 1'b1;
      carry_reg <= 1'b0;
    end else begin
      if (accu_we) begin
        accu_reg <= accu_next;
        zero_reg <= (accu_next == '0);
      end
      if (mul_last) begin
        carry_reg <= 1'b0;
      end else if (ce && idle) begin
        if (init_carry) begin
          carry_reg <= 1'b0;
        end else if (load_carry) begin
          carry_reg <= alu_cout;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      mul_a_reg   <= '0;
      prod_reg    <= '0;
      cnt_reg     <= '0;
      mul_dst_reg <= '0;
    end else if (ce) begin
      case (state_reg)
        ST_IDLE: begin
          if (mul_trig) begin
            state_reg   <= ST_MUL;
            mul_a_reg   <= accu_reg;
            prod_reg    <= {{WIDTH{1'b0}}, bank[src_sel]};
            cnt_reg     <= '0;
            mul_dst_reg <= dst_sel;
          end
        end
        ST_MUL: begin
          prod_reg <= prod_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (mul_last) begin
            state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data_out = accu_reg;
  assign rd_data  = bank[src_sel];
  assign carry    = carry_reg;
  assign zero     = zero_reg;
  assign busy     = (state_reg == ST_MUL);
  assign done     = (state_reg == ST_DONE);

endmodule
